action_scheduler: RTL and testbench
===================================

# action_scheduler

Serialises the pet's care requests (water, fertilise, prune, rest, interaction) and the periodic need-decay tick into a single command stream toward the needs/state controller. It replaces direct wiring of debounced buttons and the ultrasonic interaction flag into the needs logic. It sits between the debounce/sensor front end and the controller that owns the need counters. It provides edge capture, pending buffering, round-robin arbitration, a post-command lockout and a valid/ready handshake.

## Interface
- LOCK_CYCLES, default 50_000_000: clk cycles of lockout after each accepted care command (1 s at 50 MHz); legal range 1..2^26-1.
- NREQ, default 5: number of care requesters; fixed at 5 for this design.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  5  debounced request levels: [0] regar, [1] abonar, [2] podar, [3] reposar, [4] interaccion (button OR sensor).
- tick  in  1  one-cycle decay pulse from the time-control block (pasosegundo).
- sleeping  in  1  pet is resting; while high only reposar and tick are eligible.
- clear  in  1  synchronous soft clear (debounced reset button).
- cmd_valid  out  1  command available.
- cmd_id  out  3  0 tick, 1 regar, 2 abonar, 3 podar, 4 reposar, 5 interaccion; 6–7 unused.
- cmd_ready  in  1  consumer accepts the command this cycle.
- dropped  out  8  saturating count of request edges lost because that request was already pending.

## Operation
- Edge capture: req_q is registered each cycle. A rising edge (req & ~req_q) sets pend[i]. An edge on an already-set pend[i] increments dropped; dropped saturates at 255.
- A tick pulse sets tick_pend. A tick arriving while tick_pend is set is dropped silently; it is not counted.
- When sleeping is high, pend bits other than [3] are cleared every cycle and new edges on them are discarded. These are not counted as dropped.
- FSM states:
  - IDLE: if tick_pend, issue tick. Else if any eligible pend, issue the round-robin winner. Else stay.
  - ISSUE: cmd_valid=1 with cmd_id held. On cmd_valid&cmd_ready, clear the corresponding pend bit.
    - A care command goes to LOCK with lock_cnt=LOCK_CYCLES-1.
    - A tick goes back to IDLE, or to LOCK if it was issued from LOCK (held flag).
  - LOCK: lock_cnt decrements each cycle. At 0, go to IDLE.
    - If tick_pend, go to ISSUE for the tick and freeze lock_cnt; resume LOCK after acceptance.
    - Care requests are never issued from LOCK.
- Round robin: rr_ptr holds the index of the last granted care request. Search order is rr_ptr+1 … rr_ptr+5 mod 5. rr_ptr updates on care acceptance only.
- The tick always has priority over care requests.
- clear: next cycle, pend, tick_pend, lock_cnt and the held flag are 0, the state is IDLE and cmd_valid=0, even mid-handshake; the outstanding command is dropped. dropped and rr_ptr are not reset by clear.
- rst_n low, asynchronously:
  - state IDLE, cmd_valid=0, cmd_id=0, dropped=0;
  - pend=0, tick_pend=0, rr_ptr=4 (regar searched first);
  - req_q=0, so a req level already high at release registers as an edge.

## Timing
- All outputs are registered.
- A req edge sampled at cycle n sets pend at n+1. cmd_valid rises at n+2 when in IDLE.
- cmd_id is stable and cmd_valid stays high until the accepting edge. cmd_valid is low the cycle after acceptance.
- Back-to-back care commands: the next cmd_valid comes no earlier than accept+LOCK_CYCLES+1.
- A tick after a tick can be issued at accept+2.
- An edge on req[i] in the same cycle its pend[i] is being cleared by acceptance sets pend[i] again and is not counted as dropped.
- The tick pulse and a care edge in the same cycle are both captured.

## Structure
- Shared package tamaguchi_pkg holds:
  - the CMD_TICK..CMD_INTERACCION localparams;
  - the requester index constants;
  - the state encoding.
- One sub-module, rr_pick: combinational 5-way rotating priority encoder (pend, rr_ptr → any, idx).
- Lock counter width is $clog2(LOCK_CYCLES+1).

## Test plan
All scenarios use LOCK_CYCLES=4.
- Reset release with req=0, then a pulse on req[1]: cmd_valid rises 2 cycles after the edge with cmd_id=2. Hold cmd_ready=0 for 3 cycles: cmd_id stays 2. After acceptance the next care command does not appear for 4 cycles.
- req[0], req[2] and req[4] edges in the same cycle, cmd_ready=1: commands issue in order 1, 3, 5, each separated by the lockout. rr_ptr ends at 4.
- Tick pulse during LOCK with 2 lock cycles remaining: the tick issues (cmd_id=0). Lock then resumes and expires after exactly 2 more cycles.
- Three edges on req[3] while pend[3] is set and cmd_ready=0: dropped=2 … verify the counter saturates at 255 after 300 extra edges.
- sleeping=1 with pend[0] and pend[3] set: only cmd_id=4 issues, and pend[0] is cleared.
- clear asserted while cmd_valid=1: the next cycle has cmd_valid=0 and state IDLE. rst_n pulsed low mid-LOCK: outputs reset immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/tamaguchi_pkg.sv
// Shared definitions for the pet care command path.
// Holds the command identifiers seen by the needs/state controller,
// the care requester bit positions, the scheduler state encoding,
// and a helper that maps a requester index to its command id.
package tamaguchi_pkg;

   localparam int unsigned NUM_CARE = 5;

   // Command identifiers on cmd_id
   localparam logic [2:0] CMD_TICK        = 3'd0;
   localparam logic [2:0] CMD_REGAR       = 3'd1;
   localparam logic [2:0] CMD_ABONAR      = 3'd2;
   localparam logic [2:0] CMD_PODAR       = 3'd3;
   localparam logic [2:0] CMD_REPOSAR     = 3'd4;
   localparam logic [2:0] CMD_INTERACCION = 3'd5;

   // Bit positions within the req vector
   localparam int unsigned REQ_REGAR       = 0;
   localparam int unsigned REQ_ABONAR      = 1;
   localparam int unsigned REQ_PODAR       = 2;
   localparam int unsigned REQ_REPOSAR     = 3;
   localparam int unsigned REQ_INTERACCION = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StLock  = 2'd2
   } sched_state_e;

   // Care requester i is reported as command i+1; 0 is reserved for the tick.
   function automatic logic [2:0] care_cmd(input logic [2:0] idx);
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 5-way rotating priority encoder.
// Ports:
//   pend   - eligible pending care requests
//   rr_ptr - index of the most recently granted requester
//   any    - at least one request is eligible
//   idx    - winning index, searched from rr_ptr+1 upward modulo 5
module rr_pick
   import tamaguchi_pkg::*;
(
   input  logic [NUM_CARE-1:0] pend,
   input  logic [2:0]          rr_ptr,
   output logic                any,
   output logic [2:0]          idx
);

   logic [2:0] cand;

   // Walk from the farthest slot to the nearest so the nearest hit is the last write.
   always_comb begin
      any  = 1'b0;
      idx  = 3'd0;
      cand = 3'd0;
      for (int k = NUM_CARE; k >= 1; k--) begin
         cand = 3'((int'(rr_ptr) + k) % int'(NUM_CARE));
         if (pend[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/action_scheduler.sv
// Serialises care requests and the need-decay tick into one command stream.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req[4:0]            - debounced request levels (edge captured internally)
//   tick                - one-cycle decay pulse, always highest priority
//   sleeping            - only reposar and tick are eligible while high
//   clear               - synchronous soft clear of pending work and lockout
//   cmd_valid/cmd_id    - registered command output, held until cmd_ready
//   cmd_ready           - consumer accepts the command
//   dropped[7:0]        - saturating count of edges lost to an already-pending request
module action_scheduler
   import tamaguchi_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = 50_000_000,
   parameter int unsigned NREQ        = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            tick,
   input  logic            sleeping,
   input  logic            clear,
   output logic            cmd_valid,
   output logic [2:0]      cmd_id,
   input  logic            cmd_ready,
   output logic [7:0]      dropped
);

   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

   sched_state_e     state_q, state_d;
   logic [NREQ-1:0]  req_q, pend_q, pend_d;
   logic             tick_pend_q, tick_pend_d;
   logic             held_q, held_d;
   logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic [2:0]       cmd_id_q, cmd_id_d;
   logic [7:0]       dropped_q, dropped_d;

   logic [NREQ-1:0]  rise, elig_mask, elig_pend;
   logic             accept, pick_any;
   logic [2:0]       pick_idx, acc_idx;

   always_comb begin
      elig_mask = '1;
      if (sleeping) begin
         elig_mask = '0;
         elig_mask[REQ_REPOSAR] = 1'b1;
      end
   end

   assign rise      = req & ~req_q;
   assign elig_pend = pend_q & elig_mask;
   // A clear in the accepting cycle cancels the handshake outright.
   assign accept    = cmd_valid_q & cmd_ready & ~clear;
   assign acc_idx   = cmd_id_q - 3'd1;

   rr_pick u_rr_pick (
      .pend   (elig_pend),
      .rr_ptr (rr_ptr_q),
      .any    (pick_any),
      .idx    (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      tick_pend_d = tick_pend_q;
      held_d      = held_q;
      lock_cnt_d  = lock_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      cmd_valid_d = cmd_valid_q;
      cmd_id_d    = cmd_id_q;
      dropped_d   = dropped_q;

      // Retire the accepted command first so a same-cycle edge re-arms it.
      if (accept) begin
         if (cmd_id_q == CMD_TICK) tick_pend_d = 1'b0;
         else                      pend_d[acc_idx] = 1'b0;
      end

      for (int i = 0; i < NREQ; i++) begin
         if (rise[i] && elig_mask[i]) begin
            if (pend_q[i] && !(accept && cmd_id_q != CMD_TICK && acc_idx == 3'(i)) &&
                dropped_d != 8'hFF) begin
               dropped_d = dropped_d + 8'd1;
            end
            pend_d[i] = 1'b1;
         end
      end
      pend_d = pend_d & elig_mask;

      if (tick) tick_pend_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (tick_pend_q) begin
               state_d     = StIssue;
               cmd_valid_d = 1'b1;
               cmd_id_d    = CMD_TICK;
            end else if (pick_any) begin
               state_d     = StIssue;
               cmd_valid_d = 1'b1;
               cmd_id_d    = care_cmd(pick_idx);
            end
         end
         StIssue: begin
            if (accept) begin
               cmd_valid_d = 1'b0;
               if (cmd_id_q == CMD_TICK) begin
                  state_d = held_q ? StLock : StIdle;
                  held_d  = 1'b0;
               end else begin
                  state_d    = StLock;
                  lock_cnt_d = LockW'(LOCK_CYCLES - 1);
                  rr_ptr_d   = acc_idx;
               end
            end
         end
         StLock: begin
            // A tick interrupts the lockout with the counter frozen.
            if (tick_pend_q) begin
               state_d     = StIssue;
               cmd_valid_d = 1'b1;
               cmd_id_d    = CMD_TICK;
               held_d      = 1'b1;
            end else if (lock_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               lock_cnt_d = lock_cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (clear) begin
         state_d     = StIdle;
         pend_d      = '0;
         tick_pend_d = 1'b0;
         held_d      = 1'b0;
         lock_cnt_d  = '0;
         cmd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         req_q       <= '0;
         pend_q      <= '0;
         tick_pend_q <= 1'b0;
         held_q      <= 1'b0;
         lock_cnt_q  <= '0;
         rr_ptr_q    <= 3'd4;  // regar is searched first after reset
         cmd_valid_q <= 1'b0;
         cmd_id_q    <= 3'd0;
         dropped_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         req_q       <= req;
         pend_q      <= pend_d;
         tick_pend_q <= tick_pend_d;
         held_q      <= held_d;
         lock_cnt_q  <= lock_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_id_q    <= cmd_id_d;
         dropped_q   <= dropped_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_id    = cmd_id_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler with a short lockout.
module tb_action_scheduler;

   localparam int LOCK = 4;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic       tick;
   logic       sleeping;
   logic       clear;
   logic       cmd_valid;
   logic [2:0] cmd_id;
   logic       cmd_ready;
   logic [7:0] dropped;

   int checks = 0;
   int errors = 0;

   action_scheduler #(
      .LOCK_CYCLES (LOCK),
      .NREQ        (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .tick      (tick),
      .sleeping  (sleeping),
      .clear     (clear),
      .cmd_valid (cmd_valid),
      .cmd_id    (cmd_id),
      .cmd_ready (cmd_ready),
      .dropped   (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending sets, an outstanding command, and a lockout budget
   // counted in cycles that is only spent while no tick is waiting.
   bit [4:0] m_pend;
   bit [4:0] m_req_prev;
   bit       m_tick;
   bit       m_valid;
   int       m_id;
   int       m_lock_left;
   int       m_rr;
   int       m_dropped;

   task automatic model_reset();
      m_pend = 0; m_req_prev = 0; m_tick = 0; m_valid = 0;
      m_id = 0; m_lock_left = 0; m_rr = 4; m_dropped = 0;
   endtask

   function automatic int model_winner();
      for (int k = 1; k <= 5; k++) begin
         int c = (m_rr + k) % 5;
         if (m_pend[c] && (!sleeping || c == 3)) return c;
      end
      return -1;
   endfunction

   task automatic model_step();
      bit [4:0] edges;
      bit [4:0] np;
      bit       nt;
      bit       acc;
      int       w;
      edges = req & ~m_req_prev;
      acc   = m_valid && cmd_ready && !clear;
      np    = m_pend;
      nt    = m_tick;
      if (acc) begin
         if (m_id == 0) nt = 0;
         else           np[m_id-1] = 0;
      end
      for (int i = 0; i < 5; i++) begin
         if (edges[i] && (!sleeping || i == 3)) begin
            if (m_pend[i] && !(acc && m_id == i + 1) && m_dropped < 255) m_dropped++;
            np[i] = 1;
         end
      end
      if (sleeping) np = np & 5'b01000;
      if (tick) nt = 1;
      if (clear) begin
         m_valid = 0; m_lock_left = 0; np = 0; nt = 0;
      end else if (m_valid) begin
         if (acc) begin
            m_valid = 0;
            if (m_id != 0) begin
               m_lock_left = LOCK;
               m_rr = m_id - 1;
            end
         end
      end else if (m_lock_left > 0) begin
         if (m_tick) begin
            m_valid = 1; m_id = 0;
         end else begin
            m_lock_left--;
         end
      end else if (m_tick) begin
         m_valid = 1; m_id = 0;
      end else begin
         w = model_winner();
         if (w >= 0) begin
            m_valid = 1; m_id = w + 1;
         end
      end
      m_pend = np; m_tick = nt; m_req_prev = req;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   // One clock: model advances on the edge, outputs compared 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("model_valid", int'(cmd_valid), int'(m_valid));
      if (m_valid) check("model_id", int'(cmd_id), m_id);
      check("model_dropped", int'(dropped), m_dropped);
   endtask

   task automatic do_reset();
      req = 0; tick = 0; sleeping = 0; clear = 0; cmd_ready = 0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_id", int'(cmd_id), 0);
      check("rst_dropped", int'(dropped), 0);
   endtask

   task automatic wait_cmd(input string nm, input int exp_id, input int budget, output int waited);
      waited = 0;
      while (!cmd_valid && waited < budget) begin
         cycle();
         waited++;
      end
      if (!cmd_valid) check({nm, "_timeout"}, 0, 1);
      else            check({nm, "_id"}, int'(cmd_id), exp_id);
   endtask

   typedef struct {
      logic [4:0] req;
      logic       tick;
      logic       ready;
      logic       exp_valid;
      logic [2:0] exp_id;
      logic [7:0] exp_dropped;
   } vec_t;

   function automatic vec_t mkv(logic [4:0] r, logic t, logic rd, logic v, logic [2:0] id,
                                logic [7:0] d);
      vec_t x;
      x.req = r; x.tick = t; x.ready = rd; x.exp_valid = v; x.exp_id = id; x.exp_dropped = d;
      return x;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[19];
      int   w;
      int   seen;

      vecs[0]  = mkv(5'b00000, 0, 0, 0, 0, 0);
      vecs[1]  = mkv(5'b00010, 0, 0, 0, 0, 0);  // abonar edge
      vecs[2]  = mkv(5'b00000, 0, 0, 1, 2, 0);  // valid two cycles after the edge
      vecs[3]  = mkv(5'b00010, 0, 0, 1, 2, 1);  // second edge while pending is dropped
      vecs[4]  = mkv(5'b00000, 0, 0, 1, 2, 1);
      vecs[5]  = mkv(5'b00000, 0, 0, 1, 2, 1);
      vecs[6]  = mkv(5'b00001, 0, 1, 0, 0, 1);  // accept; regar edge queued
      vecs[7]  = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[8]  = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[9]  = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[10] = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[11] = mkv(5'b00000, 0, 1, 1, 1, 1);  // lockout over
      vecs[12] = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[13] = mkv(5'b00000, 1, 1, 0, 0, 1);  // tick during lockout
      vecs[14] = mkv(5'b00000, 0, 1, 1, 0, 1);
      vecs[15] = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[16] = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[17] = mkv(5'b00000, 0, 1, 0, 0, 1);
      vecs[18] = mkv(5'b00000, 0, 1, 0, 0, 1);

      do_reset();
      for (int n = 0; n < 19; n++) begin
         req = vecs[n].req; tick = vecs[n].tick; cmd_ready = vecs[n].ready;
         cycle();
         check($sformatf("tbl%0d_valid", n), int'(cmd_valid), int'(vecs[n].exp_valid));
         if (vecs[n].exp_valid) check($sformatf("tbl%0d_id", n), int'(cmd_id), int'(vecs[n].exp_id));
         check($sformatf("tbl%0d_dropped", n), int'(dropped), int'(vecs[n].exp_dropped));
      end

      // Simultaneous regar/podar/interaccion edges are served in rotation.
      do_reset();
      cmd_ready = 1; req = 5'b10101;
      cycle();
      req = 0;
      wait_cmd("rr_first", 1, 4, w);
      cycle();
      wait_cmd("rr_second", 3, 12, w);
      check("rr_gap2", w, LOCK + 1);
      cycle();
      wait_cmd("rr_third", 5, 12, w);
      check("rr_gap3", w, LOCK + 1);
      cycle();
      req = 5'b10001;
      cycle();
      req = 0;
      wait_cmd("rr_wrap", 1, 12, w);  // pointer sits at interaccion, so regar wins

      // Tick with two lockout cycles left; lockout resumes for exactly two more.
      do_reset();
      cmd_ready = 1; req = 5'b00001;
      cycle();
      req = 0;
      wait_cmd("lk_pre", 1, 4, w);
      cycle();                          // accepted, lockout starts
      req = 5'b00100; cycle();          // podar queued behind the lockout
      req = 0; tick = 1; cycle();
      tick = 0; cycle();
      check("lk_tick_valid", int'(cmd_valid), 1);
      check("lk_tick_id", int'(cmd_id), 0);
      cycle();
      check("lk_after_tick", int'(cmd_valid), 0);
      cycle();
      check("lk_resume1", int'(cmd_valid), 0);
      cycle();
      check("lk_resume2", int'(cmd_valid), 0);
      cycle();
      check("lk_expire_valid", int'(cmd_valid), 1);
      check("lk_expire_id", int'(cmd_id), 3);

      // Drop counting and saturation.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         req = 5'b01000; cycle();
         req = 0;        cycle();
      end
      check("drop_three_edges", int'(dropped), 2);
      for (int p = 0; p < 300; p++) begin
         req = 5'b01000; cycle();
         req = 0;        cycle();
      end
      check("drop_saturate", int'(dropped), 255);

      // Sleeping: only reposar survives.
      do_reset();
      req = 5'b00010; cycle();
      req = 0;
      wait_cmd("sl_pre", 2, 4, w);
      cmd_ready = 1; cycle();
      cmd_ready = 0; req = 5'b01001; cycle();
      req = 0; sleeping = 1; cmd_ready = 1;
      wait_cmd("sl_reposar", 4, 12, w);
      cycle();
      sleeping = 0;
      seen = 0;
      for (int p = 0; p < 12; p++) begin
         cycle();
         if (cmd_valid) seen++;
      end
      check("sl_regar_cleared", seen, 0);

      // Clear mid-handshake, then asynchronous reset mid-lockout.
      do_reset();
      req = 5'b00100; cycle();
      req = 0;
      wait_cmd("cl_pre", 3, 4, w);
      req = 5'b00100; cycle();
      req = 0;        cycle();
      clear = 1; cycle();
      clear = 0;
      check("cl_valid", int'(cmd_valid), 0);
      check("cl_keeps_dropped", int'(dropped), 1);
      repeat (3) cycle();
      check("cl_pend_gone", int'(cmd_valid), 0);
      req = 5'b10000; cycle();
      req = 0;        cycle();
      check("cl_idle_valid", int'(cmd_valid), 1);
      check("cl_idle_id", int'(cmd_id), 5);
      cmd_ready = 1; cycle();
      cmd_ready = 0; cycle();
      #2 rst_n = 1'b0;
      #1;
      check("async_valid", int'(cmd_valid), 0);
      check("async_id", int'(cmd_id), 0);
      check("async_dropped", int'(dropped), 0);

      // Randomised traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 5; b++) if ($urandom_range(3) == 0) req[b] = ~req[b];
         tick = ($urandom_range(9) == 0);
         if ($urandom_range(63) == 0) sleeping = ~sleeping;
         clear = ($urandom_range(99) == 0);
         cmd_ready = 1'($urandom_range(1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
